// File: rtl/wb_slave_mux_n.sv
// Wishbone master-to-N-slave address decoder and mux, one transaction in flight at a time.
// Unmapped or timed-out accesses return err and are logged in o_err_addr / o_err_count.
module wb_slave_mux_n #(
  parameter int                     N_SLAVES   = 4,
  parameter int                     DATA_W     = 32,
  parameter logic [N_SLAVES*32-1:0] SLAVE_BASE = {32'h8000_0000, 32'h4000_0000, 32'h0100_0000, 32'h0000_0000},
  parameter logic [N_SLAVES*32-1:0] SLAVE_MASK = {32'hFFFF_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000},
  parameter int                     TIMEOUT    = 255
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wb_cyc,
  input  logic                       i_wb_stb,
  input  logic                       i_wb_we,
  input  logic [31:0]                i_wb_addr,
  input  logic [DATA_W-1:0]          i_wb_data,
  input  logic [DATA_W/8-1:0]        i_wb_sel,
  output logic                       o_wb_stall,
  output logic                       o_wb_ack,
  output logic                       o_wb_err,
  output logic [DATA_W-1:0]          o_wb_data,
  output logic [N_SLAVES-1:0]        o_wbs_cyc,
  output logic [N_SLAVES-1:0]        o_wbs_stb,
  output logic                       o_wbs_we,
  output logic [31:0]                o_wbs_addr,
  output logic [DATA_W-1:0]          o_wbs_data,
  output logic [DATA_W/8-1:0]        o_wbs_sel,
  input  logic [N_SLAVES-1:0]        i_wbs_stall,
  input  logic [N_SLAVES-1:0]        i_wbs_ack,
  input  logic [N_SLAVES*DATA_W-1:0] i_wbs_data,
  output logic [31:0]                o_err_addr,
  output logic [7:0]                 o_err_count
);

  localparam int SEL_W = DATA_W / 8;
  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP,
    S_ERR
  } state_t;

  state_t state, state_next;

  logic [31:0]         lat_addr;
  logic [DATA_W-1:0]   lat_data;
  logic                lat_we;
  logic [SEL_W-1:0]    lat_sel;
  logic [IDX_W-1:0]    lat_idx;

  logic                dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic [IDX_W-1:0]    cyc_idx;

  logic                sel_stall;
  logic                sel_ack;
  logic [DATA_W-1:0]   sel_rdata;

  logic [15:0]         tmo_cnt;
  logic [15:0]         tmo_inc;
  logic                tmo_hit;

  logic [N_SLAVES-1:0] cyc_next, stb_next;
  logic [N_SLAVES-1:0] cyc_q, stb_q;
  logic                ack_q, err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [31:0]         err_addr_q;
  logic [7:0]          err_cnt_q;

  // Scan from the top down so the lowest matching slot is the one left standing.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int k = N_SLAVES - 1; k >= 0; k--) begin
      if ((i_wb_addr & SLAVE_MASK[32*k +: 32]) == SLAVE_BASE[32*k +: 32]) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(k);
      end
    end
  end

  assign sel_stall = i_wbs_stall[lat_idx];
  assign sel_ack   = i_wbs_ack[lat_idx];
  assign sel_rdata = i_wbs_data[lat_idx*DATA_W +: DATA_W];

  // Incremented value is compared so exactly TIMEOUT cycles are spent in REQ/WAIT.
  assign tmo_inc = tmo_cnt + 16'd1;
  assign tmo_hit = (tmo_inc == 16'(TIMEOUT));

  // The latched index is not yet valid on the accept cycle.
  assign cyc_idx = (state == S_IDLE) ? dec_idx : lat_idx;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          state_next = dec_hit ? S_REQ : S_ERR;
        end
      end
      S_REQ: begin
        if (!i_wb_cyc) begin
          state_next = S_IDLE;
        end else if (!sel_stall && sel_ack) begin
          state_next = S_RESP;
        end else if (tmo_hit) begin
          state_next = S_ERR;
        end else if (!sel_stall) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!i_wb_cyc) begin
          state_next = S_IDLE;
        end else if (sel_ack) begin
          state_next = S_RESP;
        end else if (tmo_hit) begin
          state_next = S_ERR;
        end
      end
      S_RESP:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    cyc_next = '0;
    stb_next = '0;
    if (state_next == S_REQ || state_next == S_WAIT) begin
      cyc_next[cyc_idx] = 1'b1;
    end
    if (state_next == S_REQ) begin
      stb_next[cyc_idx] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      cyc_q      <= '0;
      stb_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
      tmo_cnt    <= '0;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_we     <= 1'b0;
      lat_sel    <= '0;
      lat_idx    <= '0;
    end else begin
      state   <= state_next;
      cyc_q   <= cyc_next;
      stb_q   <= stb_next;
      ack_q   <= (state_next == S_RESP);
      rdata_q <= (state_next == S_RESP && !lat_we) ? sel_rdata : '0;
      err_q   <= (state == S_ERR);

      if (state == S_IDLE) begin
        tmo_cnt <= '0;
      end else if (state == S_REQ || state == S_WAIT) begin
        tmo_cnt <= tmo_inc;
      end

      if (state == S_IDLE && i_wb_cyc && i_wb_stb) begin
        lat_addr <= i_wb_addr;
        lat_data <= i_wb_data;
        lat_we   <= i_wb_we;
        lat_sel  <= i_wb_sel;
        lat_idx  <= dec_idx;
      end

      if (state == S_ERR) begin
        err_addr_q <= lat_addr;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
      end
    end
  end

  assign o_wb_stall  = (state != S_IDLE);
  assign o_wb_ack    = ack_q;
  assign o_wb_err    = err_q;
  assign o_wb_data   = rdata_q;
  assign o_wbs_cyc   = cyc_q;
  assign o_wbs_stb   = stb_q;
  assign o_wbs_we    = lat_we;
  assign o_wbs_addr  = lat_addr;
  assign o_wbs_data  = lat_data;
  assign o_wbs_sel   = lat_sel;
  assign o_err_addr  = err_addr_q;
  assign o_err_count = err_cnt_q;

  a_one_slave: assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(o_wbs_cyc));
  a_ack_xor_err: assert property (@(posedge i_clk) disable iff (i_rst) !(o_wb_ack && o_wb_err));

endmodule

// File: tb/tb_wb_slave_mux_n.sv
// Randomized bench for wb_slave_mux_n: per-transaction expectations come from a cycle-count model.
module tb_wb_slave_mux_n;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 10;

  logic            clk = 1'b0;
  logic            i_rst;
  logic            i_wb_cyc, i_wb_stb, i_wb_we;
  logic [31:0]     i_wb_addr;
  logic [DW-1:0]   i_wb_data;
  logic [SW-1:0]   i_wb_sel;
  logic            o_wb_stall, o_wb_ack, o_wb_err;
  logic [DW-1:0]   o_wb_data;
  logic [N-1:0]    o_wbs_cyc, o_wbs_stb;
  logic            o_wbs_we;
  logic [31:0]     o_wbs_addr;
  logic [DW-1:0]   o_wbs_data;
  logic [SW-1:0]   o_wbs_sel;
  logic [N-1:0]    i_wbs_stall, i_wbs_ack;
  logic [N*DW-1:0] i_wbs_data;
  logic [31:0]     o_err_addr;
  logic [7:0]      o_err_count;

  int          vectors = 0;
  int          miscompares = 0;
  int          err_cnt_model = 0;
  logic [31:0] err_addr_model = '0;

  always #5 clk = ~clk;

  wb_slave_mux_n #(.N_SLAVES(N), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err), .o_wb_data(o_wb_data),
    .o_wbs_cyc(o_wbs_cyc), .o_wbs_stb(o_wbs_stb), .o_wbs_we(o_wbs_we),
    .o_wbs_addr(o_wbs_addr), .o_wbs_data(o_wbs_data), .o_wbs_sel(o_wbs_sel),
    .i_wbs_stall(i_wbs_stall), .i_wbs_ack(i_wbs_ack), .i_wbs_data(i_wbs_data),
    .o_err_addr(o_err_addr), .o_err_count(o_err_count)
  );

  // Address map of the default parameters, slot k as (base, mask).
  function automatic int ref_decode(input logic [31:0] a);
    logic [31:0] b [4];
    logic [31:0] m [4];
    b = '{32'h0000_0000, 32'h0100_0000, 32'h4000_0000, 32'h8000_0000};
    m = '{32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFFFF_0000};
    for (int k = 0; k < 4; k++) begin
      if ((a & m[k]) == b[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0:       return {8'h00, r[23:0]};
      1:       return {8'h01, r[23:0]};
      2:       return {8'h40, r[23:0]};
      3:       return {16'h8000, r[15:0]};
      default: return r;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_noise(input int tgt);
    for (int j = 0; j < N; j++) begin
      if (j != tgt) begin
        i_wbs_stall[j]         = 1'($urandom);
        i_wbs_ack[j]           = 1'($urandom);
        i_wbs_data[j*DW +: DW] = $urandom;
      end
    end
  endtask

  task automatic quiet_slaves();
    i_wbs_stall = '0;
    i_wbs_ack   = '0;
    i_wbs_data  = '0;
  endtask

  // One master transaction. Target slave stalls s cycles, then acks d cycles after taking stb.
  // Cycle c counts from 1 = first cycle after the accept edge.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [SW-1:0] sel, input int s, input int d,
                         input logic [31:0] rdata, input int extra, input string tag);
    int t, ack_cyc, exp_end, exp_cyc, exp_stb, exp_first_ack, exp_first_err;
    bit exp_ack;
    int n_ack, n_err, first_ack, first_err, cyc_t, cyc_other, stb_t, bus_bad, stall_bad, both;
    logic [31:0] data_at_ack, exp_data;

    t = ref_decode(addr);
    ack_cyc = s + 1 + d;
    if (t < 0) begin
      exp_ack = 0; exp_end = 2; exp_cyc = 0; exp_stb = 0;
    end else if (ack_cyc <= TMO) begin
      exp_ack = 1; exp_end = ack_cyc + 1; exp_cyc = ack_cyc; exp_stb = s + 1;
    end else begin
      exp_ack = 0; exp_end = TMO + 2; exp_cyc = TMO; exp_stb = (s + 1 < TMO) ? s + 1 : TMO;
    end
    exp_first_ack = exp_ack ? exp_end : 0;
    exp_first_err = exp_ack ? 0 : exp_end;
    exp_data = we ? 32'h0 : rdata;
    if (!exp_ack) begin
      err_addr_model = addr;
      if (err_cnt_model < 255) err_cnt_model++;
    end

    n_ack = 0; n_err = 0; first_ack = 0; first_err = 0; cyc_t = 0; cyc_other = 0;
    stb_t = 0; bus_bad = 0; stall_bad = 0; both = 0; data_at_ack = 'x;

    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = we; i_wb_addr = addr; i_wb_data = wdata; i_wb_sel = sel;
    drive_noise(t);
    if (t >= 0) begin
      i_wbs_stall[t] = 1'b0;
      i_wbs_ack[t]   = 1'b0;
    end
    tick();
    i_wb_stb = 0; i_wb_addr = $urandom; i_wb_data = $urandom; i_wb_we = 1'($urandom);
    i_wb_sel = SW'($urandom);

    for (int c = 1; c <= exp_end + extra; c++) begin
      drive_noise(t);
      if (t >= 0) begin
        i_wbs_stall[t]         = (c <= s);
        i_wbs_ack[t]           = (c == ack_cyc);
        i_wbs_data[t*DW +: DW] = (c == ack_cyc) ? rdata : $urandom;
      end
      if (o_wb_ack === 1'b1) begin
        n_ack++;
        if (first_ack == 0) first_ack = c;
        data_at_ack = o_wb_data;
      end
      if (o_wb_err === 1'b1) begin
        n_err++;
        if (first_err == 0) first_err = c;
      end
      if (o_wb_ack === 1'b1 && o_wb_err === 1'b1) both++;
      for (int j = 0; j < N; j++) begin
        if (o_wbs_cyc[j] === 1'b1) begin
          if (j == t) cyc_t++;
          else cyc_other++;
        end
      end
      if (t >= 0 && o_wbs_stb[t] === 1'b1) begin
        stb_t++;
        if (o_wbs_addr !== addr || o_wbs_we !== we || o_wbs_data !== wdata || o_wbs_sel !== sel)
          bus_bad++;
      end
      if (c < exp_end && o_wb_stall !== 1'b1) stall_bad++;
      if (o_wb_ack === 1'b1 || o_wb_err === 1'b1) i_wb_cyc = 0;
      tick();
    end
    i_wb_cyc = 0;
    quiet_slaves();

    vectors++; if (first_ack !== exp_first_ack) begin miscompares++;
      $display("FAIL %s ack_cycle got %0d want %0d", tag, first_ack, exp_first_ack); end
    vectors++; if (first_err !== exp_first_err) begin miscompares++;
      $display("FAIL %s err_cycle got %0d want %0d", tag, first_err, exp_first_err); end
    vectors++; if (n_ack !== int'(exp_ack)) begin miscompares++;
      $display("FAIL %s ack_pulses got %0d want %0d", tag, n_ack, int'(exp_ack)); end
    vectors++; if (n_err !== int'(!exp_ack)) begin miscompares++;
      $display("FAIL %s err_pulses got %0d want %0d", tag, n_err, int'(!exp_ack)); end
    vectors++; if (both !== 0) begin miscompares++;
      $display("FAIL %s ack_and_err got %0d want 0", tag, both); end
    vectors++; if (cyc_t !== exp_cyc) begin miscompares++;
      $display("FAIL %s target_cyc_cycles got %0d want %0d", tag, cyc_t, exp_cyc); end
    vectors++; if (cyc_other !== 0) begin miscompares++;
      $display("FAIL %s other_cyc_cycles got %0d want 0", tag, cyc_other); end
    vectors++; if (stb_t !== exp_stb) begin miscompares++;
      $display("FAIL %s stb_cycles got %0d want %0d", tag, stb_t, exp_stb); end
    vectors++; if (bus_bad !== 0) begin miscompares++;
      $display("FAIL %s shared_bus_bad_cycles got %0d want 0", tag, bus_bad); end
    vectors++; if (stall_bad !== 0) begin miscompares++;
      $display("FAIL %s stall_low_cycles got %0d want 0", tag, stall_bad); end
    if (exp_ack) begin
      vectors++; if (data_at_ack !== exp_data) begin miscompares++;
        $display("FAIL %s read_data got %h want %h", tag, data_at_ack, exp_data); end
    end
    vectors++; if (o_err_addr !== err_addr_model) begin miscompares++;
      $display("FAIL %s err_addr got %h want %h", tag, o_err_addr, err_addr_model); end
    vectors++; if (int'(o_err_count) !== err_cnt_model) begin miscompares++;
      $display("FAIL %s err_count got %0d want %0d", tag, o_err_count, err_cnt_model); end
  endtask

  task automatic test_reset();
    i_rst = 1;
    tick();
    tick();
    vectors++; if ({o_wb_ack, o_wb_err, o_wb_stall} !== 3'b000) begin miscompares++;
      $display("FAIL reset ack_err_stall got %b want 000", {o_wb_ack, o_wb_err, o_wb_stall}); end
    vectors++; if ({o_wbs_cyc, o_wbs_stb} !== '0) begin miscompares++;
      $display("FAIL reset cyc_stb got %b want 0", {o_wbs_cyc, o_wbs_stb}); end
    vectors++; if (o_wb_data !== '0) begin miscompares++;
      $display("FAIL reset wb_data got %h want 0", o_wb_data); end
    vectors++; if ({o_err_addr, o_err_count} !== 40'h0) begin miscompares++;
      $display("FAIL reset err_regs got %h/%0d want 0/0", o_err_addr, o_err_count); end
    i_rst = 0;
    err_cnt_model = 0;
    err_addr_model = '0;
    tick();
  endtask

  task automatic test_read_fast();
    run_txn(32'h4000_0010, 1'b0, $urandom, 4'hF, 0, 0, 32'hDEAD_BEEF, 2, "read_fast");
  endtask

  task automatic test_write_stall();
    run_txn(32'h8000_0004, 1'b1, 32'hA5A5_5A5A, 4'h3, 3, 2, $urandom, 2, "write_stall");
  endtask

  task automatic test_unmapped();
    run_txn(32'hF000_0000, 1'b0, $urandom, 4'hF, 0, 0, $urandom, 2, "unmapped");
  endtask

  task automatic test_timeout_saturate();
    run_txn(32'h0000_1000, 1'b0, $urandom, 4'hF, 0, 50, $urandom, 2, "timeout");
    for (int i = 0; i < 299; i++) begin
      run_txn({8'h00, 24'($urandom)}, 1'($urandom), $urandom, 4'hF,
              $urandom_range(0, 12), 50, $urandom, 0, "saturate");
    end
    vectors++; if (o_err_count !== 8'd255) begin miscompares++;
      $display("FAIL saturate final_err_count got %0d want 255", o_err_count); end
  endtask

  task automatic test_abort();
    int n_resp;
    int n_cyc;
    n_resp = 0;
    n_cyc = 0;
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0; i_wb_addr = 32'h0100_0040; i_wb_sel = 4'hF;
    drive_noise(1);
    i_wbs_stall[1] = 0; i_wbs_ack[1] = 0;
    tick();
    i_wb_stb = 0;
    for (int c = 1; c <= 6; c++) begin
      drive_noise(1);
      i_wbs_stall[1] = 1'b0;
      i_wbs_ack[1]   = (c == 3);
      if (c == 2) begin
        vectors++; if (o_wbs_cyc !== 4'b0010 || o_wbs_stb !== 4'b0000) begin miscompares++;
          $display("FAIL abort wait_cyc_stb got %b/%b want 0010/0000", o_wbs_cyc, o_wbs_stb); end
        i_wb_cyc = 0;
      end
      if (o_wb_ack === 1'b1 || o_wb_err === 1'b1) n_resp++;
      if (c >= 3 && o_wbs_cyc !== 4'b0000) n_cyc++;
      if (c == 3) begin
        vectors++; if (o_wb_stall !== 1'b0) begin miscompares++;
          $display("FAIL abort stall_after got %b want 0", o_wb_stall); end
      end
      tick();
    end
    quiet_slaves();
    vectors++; if (n_resp !== 0) begin miscompares++;
      $display("FAIL abort responses got %0d want 0", n_resp); end
    vectors++; if (n_cyc !== 0) begin miscompares++;
      $display("FAIL abort cyc_after got %0d want 0", n_cyc); end
    vectors++; if (int'(o_err_count) !== err_cnt_model || o_err_addr !== err_addr_model) begin
      miscompares++;
      $display("FAIL abort err_regs got %h/%0d want %h/%0d", o_err_addr, o_err_count,
               err_addr_model, err_cnt_model); end
    run_txn(32'h0100_0080, 1'b0, $urandom, 4'hF, 1, 1, 32'h1234_5678, 2, "after_abort");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      run_txn(rand_addr(), 1'($urandom), $urandom, SW'($urandom),
              $urandom_range(0, 2), $urandom_range(0, 3), $urandom, 0, "back_to_back");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_txn(rand_addr(), 1'($urandom), $urandom, SW'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 9), $urandom, 1, "random");
    end
  endtask

  task automatic test_reset_mid();
    int n_resp;
    n_resp = 0;
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0; i_wb_addr = 32'h4000_0100; i_wb_sel = 4'hF;
    drive_noise(2);
    i_wbs_stall[2] = 0; i_wbs_ack[2] = 0;
    tick();
    i_wb_stb = 0;
    drive_noise(2);
    i_wbs_stall[2] = 0; i_wbs_ack[2] = 0;
    tick();
    vectors++; if (o_wbs_cyc !== 4'b0100) begin miscompares++;
      $display("FAIL reset_mid wait_cyc got %b want 0100", o_wbs_cyc); end
    i_rst = 1; i_wb_cyc = 0;
    tick();
    i_rst = 0;
    err_cnt_model = 0;
    err_addr_model = '0;
    vectors++; if ({o_wb_ack, o_wb_err, o_wb_stall} !== 3'b000) begin miscompares++;
      $display("FAIL reset_mid ack_err_stall got %b want 000", {o_wb_ack, o_wb_err, o_wb_stall}); end
    vectors++; if ({o_wbs_cyc, o_wbs_stb} !== '0) begin miscompares++;
      $display("FAIL reset_mid cyc_stb got %b want 0", {o_wbs_cyc, o_wbs_stb}); end
    vectors++; if (o_wb_data !== '0 || o_err_addr !== '0 || o_err_count !== 8'd0) begin miscompares++;
      $display("FAIL reset_mid data_err_regs got %h/%h/%0d want 0/0/0", o_wb_data, o_err_addr, o_err_count); end
    for (int c = 0; c < 4; c++) begin
      drive_noise(2);
      i_wbs_stall[2] = 0;
      i_wbs_ack[2]   = (c == 0);
      if (o_wb_ack === 1'b1 || o_wb_err === 1'b1) n_resp++;
      tick();
    end
    quiet_slaves();
    vectors++; if (n_resp !== 0) begin miscompares++;
      $display("FAIL reset_mid responses got %0d want 0", n_resp); end
    run_txn(32'h8000_0010, 1'b0, $urandom, 4'hF, 0, 1, 32'hCAFE_F00D, 2, "after_reset");
  endtask

  initial begin
    i_rst = 1; i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
    i_wb_addr = '0; i_wb_data = '0; i_wb_sel = '0;
    quiet_slaves();
    test_reset();
    test_read_fast();
    test_write_stall();
    test_unmapped();
    test_timeout_saturate();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_slave_mux_n.md
WB_SLAVE_MUX_N -- requirements
Module: wb_slave_mux_n

Interface
REQ-001 SHALL have one clock, i_clk; reset is synchronous and active-high, i_rst, sampled on the rising edge of i_clk.
REQ-002 Parameters SHALL be, one per line as name, default, meaning:
- N_SLAVES, 4, number of slave ports (1..8).
- DATA_W, 32, data width, a multiple of 8.
- SLAVE_BASE, {32'h8000_0000, 32'h4000_0000, 32'h0100_0000, 32'h0000_0000}, flat N_SLAVES x 32 base vector, slot k at bits [32k+31:32k].
- SLAVE_MASK, {32'hFFFF_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000}, flat mask vector, same layout.
- TIMEOUT, 255, maximum cycles waiting for a slave (1..65535).
REQ-003 Ports SHALL be, one per line as name, direction, width, meaning:
- i_clk, in, 1, clock.
- i_rst, in, 1, synchronous active-high reset.
- i_wb_cyc / i_wb_stb / i_wb_we, in, 1 each, master cycle, strobe, write enable.
- i_wb_addr, in, 32, master address.
- i_wb_data, in, DATA_W, master write data.
- i_wb_sel, in, DATA_W/8, master byte select.
- o_wb_stall, out, 1, master stall.
- o_wb_ack, out, 1, master acknowledge.
- o_wb_err, out, 1, master error.
- o_wb_data, out, DATA_W, master read data.
- o_wbs_cyc / o_wbs_stb, out, N_SLAVES each, per-slave cycle and strobe.
- o_wbs_we, out, 1, shared write enable.
- o_wbs_addr, out, 32, shared address.
- o_wbs_data, out, DATA_W, shared write data.
- o_wbs_sel, out, DATA_W/8, shared byte select.
- i_wbs_stall / i_wbs_ack, in, N_SLAVES each, per-slave stall and ack.
- i_wbs_data, in, N_SLAVES*DATA_W, flat slave read data.
- o_err_addr, out, 32, address of the last errored request.
- o_err_count, out, 8, saturating error count.

Function
REQ-004 Decode: slave k hits when (addr & MASK[k]) == BASE[k]; the lowest-index hit wins; no hit means unmapped.
REQ-005 Exactly one transaction SHALL be outstanding at a time; states are IDLE, REQ, WAIT, RESP, ERR.
REQ-006 o_wb_stall SHALL be 0 in IDLE and 1 in every other state.
REQ-007 IDLE with i_wb_cyc&i_wb_stb: SHALL latch addr, data, we, sel and the decoded index, then go to REQ on a hit or to ERR when unmapped.
REQ-008 REQ: SHALL drive o_wbs_cyc[k]=o_wbs_stb[k]=1; when i_wbs_stall[k]=0, stb drops next cycle and the state moves to WAIT, or to RESP if i_wbs_ack[k] is high in the same cycle.
REQ-009 WAIT: SHALL keep o_wbs_cyc[k]=1 with stb=0; on i_wbs_ack[k], SHALL latch the slave k data slice and go to RESP.
REQ-010 RESP: SHALL pulse o_wb_ack=1 for exactly one cycle with o_wb_data = latched data (0 on writes), drop o_wbs_cyc, and return to IDLE.
REQ-011 ERR: SHALL pulse o_wb_err=1 for one cycle with o_wb_data=0, load o_err_addr with the latched address, increment o_err_count (saturating at 255), and return to IDLE.
REQ-012 Timeout: a 16-bit counter SHALL clear on entry to REQ and increment each cycle in REQ/WAIT; the cycle it equals TIMEOUT the state SHALL go to ERR and slave cyc/stb SHALL drop next cycle.
REQ-013 i_wbs_ack/i_wbs_stall of non-selected slaves SHALL be ignored; an ack in IDLE/RESP/ERR SHALL be ignored.
REQ-014 If i_wb_cyc falls in REQ or WAIT, the block SHALL abort to IDLE next cycle: slave cyc/stb low, no ack, no err, err registers unchanged.
REQ-015 At most one o_wbs_cyc bit SHALL be high in any cycle, and o_wb_ack and o_wb_err SHALL never both be high.
REQ-016 Minimum latency SHALL be 2 cycles from the accept edge to o_wb_ack: slave ack combinational in REQ with stall 0.
REQ-017 Shared slave buses SHALL carry the latched values from REQ through WAIT and are don't-care otherwise.

Reset
REQ-018 i_rst=1 SHALL force IDLE and set o_wb_ack, o_wb_err and all o_wbs_cyc/stb to 0, o_wb_data to 0, o_err_addr to 0, o_err_count to 0 and the timeout counter to 0 on the next edge.
REQ-019 Reset asserted mid-transaction SHALL abandon it with no ack or err pulse.

Verification
REQ-020 Read 0x4000_0010, slave 2 acks in REQ with data 0xDEADBEEF -> o_wb_ack 2 cycles after accept, o_wb_data=0xDEADBEEF, only o_wbs_cyc[2] ever high.
REQ-021 Write 0x8000_0004 with slave 3 stalling 3 cycles then acking 2 cycles later -> stb held 4 cycles, single o_wb_ack, o_wb_stall=1 throughout.
REQ-022 Access 0xF000_0000 (unmapped) -> o_wb_err 2 cycles after accept, o_err_addr=0xF000_0000, o_err_count=1, no slave cyc.
REQ-023 With TIMEOUT=10, slave 0 never acks -> o_wb_err exactly after 10 cycles in REQ/WAIT; 300 such errors -> o_err_count=255.
REQ-024 Master drops i_wb_cyc in WAIT, then a stray ack arrives -> no ack/err to the master, next transaction completes normally.
REQ-025 i_rst pulsed during WAIT -> all outputs at reset values next cycle, no ack/err pulse.
